johnson_phase_decoder: RTL and testbench

- Downstream consumer of the 4-bit Johnson counter's Q0..Q3 outputs.
- Registers the Johnson code and decodes it into a one-hot phase vector and a binary phase index.
- Checks every step against the legal Johnson successor and locks onto the sequence.
- Flags illegal codes and sequence breaks, and counts completed revolutions, so later stages can use the phases as timing strobes.

---
 rtl/johnson_phase_decoder.sv | 184 ++++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder: registers a WIDTH-bit Johnson code, decodes phase, locks onto the sequence, counts revolutions.
// Latency: outputs reflect q sampled two rising edges earlier (stage 1 register, stage 2 decode/check).
// Backpressure: none; a free-running stream consumed every clock. Optional macro JPD_HOLD_ALLOW_EN treats a repeated code as legal.
module johnson_phase_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             q,
    input  logic                         clr_err,
    output logic [2*WIDTH-1:0]           phase_onehot,
    output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
    output logic                         valid,
    output logic                         illegal_code,
    output logic                         seq_error,
    output logic                         cycle_tick,
    output logic [CNT_W-1:0]             cycle_count
);

    localparam int NS     = 2 * WIDTH;
    localparam int IDX_W  = $clog2(NS);
    localparam int LCNT_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

    // Stage-1 register plus a flag so stage 2 ignores the reset value of q_r
    logic [WIDTH-1:0]   q_r_q;
    logic               s1_vld_q;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic               have_prev_q, have_prev_d;
    logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [NS-1:0]      onehot_q, onehot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic               tick_q, tick_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               code_legal;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               good_step, hold_step, bad_step, wrap_step;

    // Decode: legal codes are thermometers filled from bit 0 up or from the top bit down
    always_comb begin
        int pc;
        int idx_int;
        logic [WIDTH-1:0] lo_therm;
        logic [WIDTH-1:0] hi_therm;
        pc       = 0;
        lo_therm = '0;
        hi_therm = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_r_q[i]) pc++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            lo_therm[i] = (i < pc);
            hi_therm[i] = (i >= WIDTH - pc);
        end
        code_legal = (q_r_q == lo_therm) || (q_r_q == hi_therm);
        idx_int    = q_r_q[WIDTH-1] ? (NS - pc) : pc;
        dec_idx    = IDX_W'(idx_int);
    end

    // Step classification against the previous legal index
    always_comb begin
        logic hold_is_bad;
`ifdef JPD_HOLD_ALLOW_EN
        hold_is_bad = 1'b0;
`else
        hold_is_bad = 1'b1;
`endif
        next_idx  = (prev_idx_q == IDX_W'(NS - 1)) ? '0 : prev_idx_q + 1'b1;
        good_step = s1_vld_q && code_legal && have_prev_q && (dec_idx == next_idx);
        hold_step = s1_vld_q && code_legal && have_prev_q && (dec_idx == prev_idx_q);
        bad_step  = s1_vld_q && (!code_legal ||
                    (have_prev_q && !good_step && (!hold_step || hold_is_bad)));
        wrap_step = good_step && (prev_idx_q == IDX_W'(NS - 1));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ACQUIRE;
        else       state_q <= state_d;
    end

    // FSM next state: lock after LOCK_COUNT good steps, drop lock on any bad step
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQUIRE: if (good_step && (lock_cnt_q + 1'b1 >= LCNT_W'(LOCK_COUNT))) state_d = LOCKED;
            LOCKED:  if (bad_step) state_d = ACQUIRE;
            default: state_d = ACQUIRE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        prev_idx_d  = prev_idx_q;
        have_prev_d = have_prev_q;
        lock_cnt_d  = lock_cnt_q;
        onehot_d    = onehot_q;
        idx_d       = idx_q;
        illegal_d   = illegal_q;
        tick_d      = 1'b0;
        count_d     = count_q;
        valid_d     = (state_d == LOCKED);
        seq_err_d   = seq_err_q;

        if (s1_vld_q) begin
            illegal_d = !code_legal;
            onehot_d  = '0;
            if (code_legal) begin
                idx_d      = dec_idx;
                prev_idx_d = dec_idx;
                for (int i = 0; i < NS; i++) begin
                    onehot_d[i] = (dec_idx == IDX_W'(i));
                end
            end
        end

        if (bad_step) begin
            lock_cnt_d  = '0;
            have_prev_d = 1'b0;
        end else if (s1_vld_q && code_legal) begin
            have_prev_d = 1'b1;
            if (good_step && state_q == ACQUIRE) lock_cnt_d = lock_cnt_q + 1'b1;
        end

        if (state_q == LOCKED && wrap_step) begin
            tick_d  = 1'b1;
            count_d = count_q + 1'b1;
        end

        // A new error on the same edge as clr_err wins
        if (state_q == LOCKED && bad_step) seq_err_d = 1'b1;
        else if (clr_err)                  seq_err_d = 1'b0;
    end

    // Pipeline and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r_q       <= '0;
            s1_vld_q    <= 1'b0;
            prev_idx_q  <= '0;
            have_prev_q <= 1'b0;
            lock_cnt_q  <= '0;
            onehot_q    <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            tick_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            q_r_q       <= q;
            s1_vld_q    <= 1'b1;
            prev_idx_q  <= prev_idx_d;
            have_prev_q <= have_prev_d;
            lock_cnt_q  <= lock_cnt_d;
            onehot_q    <= onehot_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            tick_q      <= tick_d;
            count_q     <= count_d;
        end
    end

    assign phase_onehot = onehot_q;
    assign phase_idx    = idx_q;
    assign valid        = valid_q;
    assign illegal_code = illegal_q;
    assign seq_error    = seq_err_q;
    assign cycle_tick   = tick_q;
    assign cycle_count  = count_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder (default parameters WIDTH=4, LOCK_COUNT=4, CNT_W=8).
// A reference model predicts outputs per edge; predictions are queued and compared after the edge.
// Scenario tasks add explicit checks on the behaviour each scenario targets.
module tb_johnson_phase_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic       clr_err;
    logic [7:0] phase_onehot;
    logic [2:0] phase_idx;
    logic       valid;
    logic       illegal_code;
    logic       seq_error;
    logic       cycle_tick;
    logic [7:0] cycle_count;

    johnson_phase_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .q            (q),
        .clr_err      (clr_err),
        .phase_onehot (phase_onehot),
        .phase_idx    (phase_idx),
        .valid        (valid),
        .illegal_code (illegal_code),
        .seq_error    (seq_error),
        .cycle_tick   (cycle_tick),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       vld;
        logic       ill;
        logic       serr;
        logic       tick;
        logic [7:0] cnt;
    } obs_t;

    obs_t sb[$];
    obs_t exp_o, got_o;
    int   vectors = 0;
    int   errors  = 0;
    int   pos     = 0;

    // Reference model state
    logic [3:0] m_qr;
    bit         m_s1v, m_have, m_locked;
    int         m_prev, m_lcnt;
    obs_t       m_out;

    function automatic int lut(logic [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b0001: return 1;
            4'b0011: return 2;
            4'b0111: return 3;
            4'b1111: return 4;
            4'b1110: return 5;
            4'b1100: return 6;
            4'b1000: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] code_of(int i);
        case (i % 8)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0011;
            3: return 4'b0111;
            4: return 4'b1111;
            5: return 4'b1110;
            6: return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.oh = phase_onehot; s.idx = phase_idx; s.vld = valid; s.ill = illegal_code;
        s.serr = seq_error; s.tick = cycle_tick; s.cnt = cycle_count;
        return s;
    endfunction

    task automatic model_edge(input logic [3:0] c, input logic clr, input logic rst);
        int id;
        bit good, bad, was_locked;
        logic [7:0] one;
        one = 8'h01;
        if (rst) begin
            m_qr = '0; m_s1v = 0; m_have = 0; m_locked = 0; m_prev = 0; m_lcnt = 0; m_out = '0;
            return;
        end
        m_out.tick = 1'b0;
        was_locked = m_locked;
        good = 0;
        bad  = 0;
        if (m_s1v) begin
            id = lut(m_qr);
            if (id < 0) begin
                bad = 1; m_out.ill = 1'b1; m_out.oh = '0;
            end else begin
                m_out.ill = 1'b0; m_out.oh = one << id; m_out.idx = 3'(id);
                if (m_have) begin
                    if (id == (m_prev + 1) % 8) good = 1;
                    else if (id == m_prev) begin
`ifndef JPD_HOLD_ALLOW_EN
                        bad = 1;
`endif
                    end else bad = 1;
                end
            end
            if (bad) begin
                m_locked = 0; m_lcnt = 0; m_have = 0;
            end else if (id >= 0) begin
                if (good) begin
                    if (was_locked) begin
                        if (m_prev == 7 && id == 0) begin
                            m_out.tick = 1'b1; m_out.cnt = m_out.cnt + 8'd1;
                        end
                    end else begin
                        m_lcnt++;
                        if (m_lcnt == 4) m_locked = 1;
                    end
                end
                m_prev = id; m_have = 1;
            end
        end
        if (was_locked && bad) m_out.serr = 1'b1;
        else if (clr)          m_out.serr = 1'b0;
        m_out.vld = m_locked;
        m_qr  = c;
        m_s1v = 1;
    endtask

    // Drive one clock of stimulus, queue the prediction, sample after the edge
    task automatic cycle(input logic [3:0] c, input logic clr, input logic rst);
        @(negedge clk);
        q = c; clr_err = clr; reset = rst;
        model_edge(c, clr, rst);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(4'b0000, 1'b0, 1'b1);
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL reset_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
            vectors++;
            if (got_o !== obs_t'(0)) begin errors++; $display("FAIL reset_zero got=%h want=0", got_o); end
        end
    endtask

    task automatic test_lockin();
        pos = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL lockin_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
            vectors++;
            if (illegal_code !== 1'b0 || seq_error !== 1'b0) begin
                errors++; $display("FAIL lockin_flags k=%0d ill=%b serr=%b want 0 0", k, illegal_code, seq_error);
            end
            if (k <= 5) begin
                vectors++;
                if (valid !== 1'b0) begin errors++; $display("FAIL lockin_early_valid k=%0d got=%b want=0", k, valid); end
            end
        end
        vectors++;
        if (valid !== 1'b1 || phase_idx !== 3'd4 || phase_onehot !== 8'b0001_0000) begin
            errors++; $display("FAIL lockin_edge valid=%b idx=%0d oh=%b want 1 4 00010000", valid, phase_idx, phase_onehot);
        end
    endtask

    task automatic test_revolutions();
        int ticks;
        ticks = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL rev_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
            if (cycle_tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks !== 2 || cycle_count !== 8'd2) begin
            errors++; $display("FAIL rev_count ticks=%0d count=%0d want 2 2", ticks, cycle_count);
        end
    endtask

    task automatic test_illegal();
        cycle(4'b0101, 1'b0, 1'b0);
        exp_o = sb.pop_front(); got_o = sample(); vectors++;
        if (got_o !== exp_o) begin errors++; $display("FAIL illegal_sb inj got=%h want=%h", got_o, exp_o); end
        for (int j = 0; j < 8; j++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL illegal_sb j=%0d got=%h want=%h", j, got_o, exp_o); end
            vectors++;
            if (j == 0 && (illegal_code !== 1'b1 || phase_onehot !== 8'h00 || seq_error !== 1'b1 || valid !== 1'b0)) begin
                errors++; $display("FAIL illegal_flags ill=%b oh=%b serr=%b valid=%b want 1 0 1 0", illegal_code, phase_onehot, seq_error, valid);
            end else if (j == 4 && valid !== 1'b0) begin
                errors++; $display("FAIL illegal_relock_early valid=%b want=0", valid);
            end else if (j >= 5 && (valid !== 1'b1 || seq_error !== 1'b1)) begin
                errors++; $display("FAIL illegal_relock j=%0d valid=%b serr=%b want 1 1", j, valid, seq_error);
            end
        end
        cycle(code_of(pos), 1'b1, 1'b0); pos++;
        exp_o = sb.pop_front(); got_o = sample(); vectors++;
        if (got_o !== exp_o || seq_error !== 1'b0) begin
            errors++; $display("FAIL illegal_clr serr=%b got=%h want=%h", seq_error, got_o, exp_o);
        end
    endtask

    // Run legal codes until the next code to drive has index target
    task automatic align_to(input int target, input string nm);
        for (int k = 0; k < 8 && (pos % 8) != target; k++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL %s_align got=%h want=%h", nm, got_o, exp_o); end
        end
    endtask

    // Legal codes to relock, then a clr_err pulse
    task automatic relock(input string nm);
        for (int k = 0; k < 7; k++) begin
            cycle(code_of(pos), (k == 6), 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL %s_relock k=%0d got=%h want=%h", nm, k, got_o, exp_o); end
        end
        vectors++;
        if (valid !== 1'b1 || seq_error !== 1'b0) begin
            errors++; $display("FAIL %s_relock_end valid=%b serr=%b want 1 0", nm, valid, seq_error);
        end
    endtask

    task automatic test_skip();
        align_to(2, "skip");
        cycle(4'b0111, 1'b0, 1'b0); pos += 2;
        exp_o = sb.pop_front(); got_o = sample(); vectors++;
        if (got_o !== exp_o || valid !== 1'b1 || phase_idx !== 3'd1) begin
            errors++; $display("FAIL skip_pre valid=%b idx=%0d got=%h want=%h", valid, phase_idx, got_o, exp_o);
        end
        cycle(code_of(pos), 1'b0, 1'b0); pos++;
        exp_o = sb.pop_front(); got_o = sample(); vectors++;
        if (got_o !== exp_o) begin errors++; $display("FAIL skip_sb got=%h want=%h", got_o, exp_o); end
        vectors++;
        if (seq_error !== 1'b1 || illegal_code !== 1'b0 || valid !== 1'b0 || phase_idx !== 3'd3) begin
            errors++; $display("FAIL skip_flags serr=%b ill=%b valid=%b idx=%0d want 1 0 0 3", seq_error, illegal_code, valid, phase_idx);
        end
        relock("skip");
    endtask

    task automatic test_hold();
        logic [7:0] cnt0;
        align_to(2, "hold");
        cnt0 = m_out.cnt;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin cycle(4'b0011, 1'b0, 1'b0); pos++; end
            else if (k == 1) cycle(4'b0011, 1'b0, 1'b0);
            else begin cycle(code_of(pos), 1'b0, 1'b0); pos++; end
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL hold_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
        end
        vectors++;
`ifdef JPD_HOLD_ALLOW_EN
        if (valid !== 1'b1 || seq_error !== 1'b0 || cycle_count !== cnt0) begin
            errors++; $display("FAIL hold_allowed valid=%b serr=%b cnt=%0d want 1 0 %0d", valid, seq_error, cycle_count, cnt0);
        end
`else
        if (valid !== 1'b0 || seq_error !== 1'b1 || cycle_count !== cnt0) begin
            errors++; $display("FAIL hold_bad valid=%b serr=%b cnt=%0d want 0 1 %0d", valid, seq_error, cycle_count, cnt0);
        end
`endif
        relock("hold");
    endtask

    task automatic test_midreset();
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL midrst_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
            seen = m_out.tick;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL midrst_timeout tick=%b want=1", cycle_tick); end
        cycle(4'b1000, 1'b0, 1'b1);
        exp_o = sb.pop_front(); got_o = sample(); vectors++;
        if (got_o !== exp_o || got_o !== obs_t'(0)) begin
            errors++; $display("FAIL midrst_zero got=%h want=0", got_o);
        end
        pos = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(code_of(pos), 1'b0, 1'b0); pos++;
            exp_o = sb.pop_front(); got_o = sample(); vectors++;
            if (got_o !== exp_o) begin errors++; $display("FAIL midrst_relock_sb k=%0d got=%h want=%h", k, got_o, exp_o); end
            if (k == 5) begin
                vectors++;
                if (valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid got=%b want=0", valid); end
            end
        end
        vectors++;
        if (valid !== 1'b1 || phase_idx !== 3'd4 || cycle_count !== 8'd0) begin
            errors++; $display("FAIL midrst_relock valid=%b idx=%0d cnt=%0d want 1 4 0", valid, phase_idx, cycle_count);
        end
    endtask

    initial begin
        reset   = 1'b1;
        q       = 4'b0000;
        clr_err = 1'b0;
        test_reset();
        test_lockin();
        test_revolutions();
        test_illegal();
        test_skip();
        test_hold();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
